// File: rtl/grf_wb_queue.sv
// grf_wb_queue: in-order write-back buffer in front of the GRF's single write port.
// Producers such as the mul/div unit and the load path enqueue {pc, addr, data}
// requests. The queue drains them one per cycle into the GRF. Two lookup ports
// forward the youngest queued value for a register.
// Optional build macro GRF_WB_TRACE_EN: print one trace line per drained non-$0 write.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both high.
// Input side is in_valid/in_ready. GRF side is grf_we/grf_ready. Once valid is raised,
// it and its payload stay unchanged until the transfer happens. Ready never depends
// on valid. in_ready is !full, so a full queue refuses a push even in a popping cycle.
module grf_wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_pc,
    input  logic [4:0]    in_addr,
    input  logic [31:0]   in_data,
    output logic          grf_we,
    input  logic          grf_ready,
    output logic [31:0]   grf_pc,
    output logic [4:0]    grf_addr,
    output logic [31:0]   grf_data,
    input  logic [4:0]    q_addr1,
    input  logic [4:0]    q_addr2,
    output logic          fwd_hit1,
    output logic [31:0]   fwd_data1,
    output logic          fwd_hit2,
    output logic [31:0]   fwd_data2,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    // Entry storage. Reset does not clear it, because only wp/rp/count define validity.
    logic [31:0] pc_mem   [DEPTH];
    logic [4:0]  addr_mem [DEPTH];
    logic [31:0] data_mem [DEPTH];

    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic          push;
    logic          pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign in_ready = !full;
    assign grf_we   = !empty;
    assign push     = in_valid && in_ready;
    assign pop      = grf_we && grf_ready;

    // Head of the queue feeds the GRF write port directly. It is don't-care while empty.
    assign grf_pc   = pc_mem[rp];
    assign grf_addr = addr_mem[rp];
    assign grf_data = data_mem[rp];

    // Capture an accepted request at the write pointer.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wp]   <= in_pc;
            addr_mem[wp] <= in_addr;
            data_mem[wp] <= in_data;
        end
    end

    // Pointer and occupancy bookkeeping. Reset drops all pending entries at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + AW'(1);
            if (pop)  rp <= rp + AW'(1);
            if (push && !pop)      count <= count + (AW+1)'(1);
            else if (pop && !push) count <= count - (AW+1)'(1);
        end
    end

    // Youngest-match forwarding. The scan walks oldest to youngest, so later hits
    // override earlier ones. $0 never matches. The entry being pushed this cycle is
    // not yet counted, so it cannot match.
    always_comb begin
        fwd_hit1  = 1'b0;
        fwd_data1 = '0;
        fwd_hit2  = 1'b0;
        fwd_data2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((AW+1)'(i) < count) begin
                if (q_addr1 != 5'd0 && addr_mem[rp + AW'(i)] == q_addr1) begin
                    fwd_hit1  = 1'b1;
                    fwd_data1 = data_mem[rp + AW'(i)];
                end
                if (q_addr2 != 5'd0 && addr_mem[rp + AW'(i)] == q_addr2) begin
                    fwd_hit2  = 1'b1;
                    fwd_data2 = data_mem[rp + AW'(i)];
                end
            end
        end
    end

`ifdef GRF_WB_TRACE_EN
    // Print each architecturally visible GRF write as it drains.
    always_ff @(posedge clk) begin
        if (!reset && pop && grf_addr != 5'd0) begin
            $display("@%h: $%d <= %h", grf_pc, grf_addr, grf_data);
        end
    end
`else
`endif

endmodule

// File: tb/tb_grf_wb_queue.sv
// Bench for grf_wb_queue: directed scenarios plus random traffic, checked each cycle
// against a queue-level reference model.
module tb_grf_wb_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_pc;
    logic [4:0]    in_addr;
    logic [31:0]   in_data;
    logic          grf_we;
    logic          grf_ready;
    logic [31:0]   grf_pc;
    logic [4:0]    grf_addr;
    logic [31:0]   grf_data;
    logic [4:0]    q_addr1;
    logic [4:0]    q_addr2;
    logic          fwd_hit1;
    logic [31:0]   fwd_data1;
    logic          fwd_hit2;
    logic [31:0]   fwd_data2;
    logic [AW:0]   count;
    logic          full;
    logic          empty;

    int checks = 0;
    int errors = 0;
    logic run_cmp = 1'b0;

    // Reference model. Each packed entry is {pc[68:37], addr[36:32], data[31:0]}.
    logic [68:0] exp_q[$];
    logic [4:0]  dut_drain[$];

    grf_wb_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_addr(in_addr), .in_data(in_data),
        .grf_we(grf_we), .grf_ready(grf_ready),
        .grf_pc(grf_pc), .grf_addr(grf_addr), .grf_data(grf_data),
        .q_addr1(q_addr1), .q_addr2(q_addr2),
        .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1),
        .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2),
        .count(count), .full(full), .empty(empty)
    );

    // Clock and reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model update: queue semantics straight from the rules (pop head, append new).
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            automatic bit do_pop  = (exp_q.size() > 0) && grf_ready;
            automatic bit do_push = in_valid && (exp_q.size() < DEPTH);
            if (do_pop)  void'(exp_q.pop_front());
            if (do_push) exp_q.push_back({in_pc, in_addr, in_data});
        end
    end

    // Record what the DUT hands to the GRF, in drain order.
    always @(posedge clk) begin
        if (!reset && grf_we && grf_ready) dut_drain.push_back(grf_addr);
    end

    // Youngest-match lookup over the model queue.
    function automatic logic [32:0] model_fwd(input logic [4:0] a);
        logic [32:0] r;
        r = '0;
        if (a != 5'd0) begin
            for (int i = 0; i < exp_q.size(); i++) begin
                if (exp_q[i][36:32] == a) r = {1'b1, exp_q[i][31:0]};
            end
        end
        return r;
    endfunction

    // Compare process: check every output against the model on each falling edge.
    always @(negedge clk) begin
        if (run_cmp && !reset) begin
            automatic int n = exp_q.size();
            automatic logic [32:0] f1 = model_fwd(q_addr1);
            automatic logic [32:0] f2 = model_fwd(q_addr2);
            chk("count",    32'(count),    32'(n));
            chk("grf_we",   32'(grf_we),   32'(n != 0));
            chk("full",     32'(full),     32'(n == DEPTH));
            chk("empty",    32'(empty),    32'(n == 0));
            chk("in_ready", 32'(in_ready), 32'(n != DEPTH));
            if (n != 0) begin
                chk("grf_pc",   grf_pc,          exp_q[0][68:37]);
                chk("grf_addr", 32'(grf_addr),   32'(exp_q[0][36:32]));
                chk("grf_data", grf_data,        exp_q[0][31:0]);
            end
            chk("fwd_hit1",  32'(fwd_hit1), 32'(f1[32]));
            chk("fwd_data1", fwd_data1,     f1[31:0]);
            chk("fwd_hit2",  32'(fwd_hit2), 32'(f2[32]));
            chk("fwd_data2", fwd_data2,     f2[31:0]);
        end
    end

    // Driver tasks. All input changes happen 1 time unit after a falling edge.
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] a,
                         input logic [31:0] d);
        in_valid = v;
        in_pc    = pc;
        in_addr  = a;
        in_data  = d;
    endtask

    task automatic push_one(input logic [31:0] pc, input logic [4:0] a, input logic [31:0] d);
        drive(1'b1, pc, a, d);
        cyc();
        in_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        grf_ready = 1'b0;
        q_addr1   = '0;
        q_addr2   = '0;
        drive(1'b0, '0, '0, '0);
        repeat (2) cyc();
        reset   = 1'b0;
        run_cmp = 1'b1;
        cyc();

        // Reset then idle
        chk("idle_empty",    32'(empty),    32'd1);
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        chk("idle_grf_we",   32'(grf_we),   32'd0);
        chk("idle_count",    32'(count),    32'd0);

        // Single write
        grf_ready = 1'b1;
        push_one(32'h3000, 5'd5, 32'h12345678);
        chk("single_we",   32'(grf_we),   32'd1);
        chk("single_addr", 32'(grf_addr), 32'd5);
        chk("single_data", grf_data,      32'h12345678);
        cyc();
        chk("single_empty", 32'(empty), 32'd1);

        // Fill and backpressure
        grf_ready = 1'b0;
        for (int i = 1; i <= 4; i++) push_one(32'h4000 + 32'(i * 4), 5'(i), 32'h100 + 32'(i));
        chk("fill_full",     32'(full),     32'd1);
        chk("fill_in_ready", 32'(in_ready), 32'd0);
        push_one(32'h4020, 5'd9, 32'hDEAD);
        chk("fill_count_5th", 32'(count), 32'd4);
        dut_drain.delete();
        grf_ready = 1'b1;
        repeat (4) cyc();
        chk("drain_n", 32'(dut_drain.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < dut_drain.size()) chk("drain_order", 32'(dut_drain[i]), 32'(i + 1));
        end
        chk("drain_empty", 32'(empty), 32'd1);

        // Youngest-match forwarding
        grf_ready = 1'b0;
        push_one(32'h5000, 5'd7, 32'hA);
        push_one(32'h5004, 5'd7, 32'hB);
        q_addr1 = 5'd7;
        q_addr2 = 5'd0;
        #1;
        chk("fwd_young_hit",  32'(fwd_hit1), 32'd1);
        chk("fwd_young_data", fwd_data1,     32'hB);
        chk("fwd_zero_hit",   32'(fwd_hit2), 32'd0);
        grf_ready = 1'b1;
        repeat (2) cyc();
        chk("fwd_after_drain", 32'(fwd_hit1), 32'd0);

        // Simultaneous push/pop at count=2, across pointer wrap
        grf_ready = 1'b0;
        push_one(32'h6000, 5'd3, 32'h33);
        push_one(32'h6004, 5'd4, 32'h44);
        grf_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h6100 + 32'(i * 4), 5'($urandom_range(0, 7)), $urandom);
            q_addr1 = 5'($urandom_range(0, 7));
            q_addr2 = 5'($urandom_range(0, 7));
            cyc();
            chk("pushpop_count", 32'(count), 32'd2);
        end
        in_valid = 1'b0;
        repeat (2) cyc();

        // Asynchronous reset at count=3, between edges
        grf_ready = 1'b0;
        push_one(32'h7000, 5'd10, 32'h70);
        push_one(32'h7004, 5'd11, 32'h71);
        push_one(32'h7008, 5'd12, 32'h72);
        q_addr1 = 5'd11;
        q_addr2 = 5'd12;
        #2;
        reset = 1'b1;
        #1;
        chk("areset_we",    32'(grf_we),   32'd0);
        chk("areset_count", 32'(count),    32'd0);
        chk("areset_hit1",  32'(fwd_hit1), 32'd0);
        chk("areset_hit2",  32'(fwd_hit2), 32'd0);
        cyc();
        reset     = 1'b0;
        grf_ready = 1'b1;
        push_one(32'h8000, 5'd6, 32'hCAFE);
        chk("post_reset_addr", 32'(grf_addr), 32'd6);
        chk("post_reset_data", grf_data,      32'hCAFE);
        cyc();
        chk("post_reset_empty", 32'(empty), 32'd1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 7)), $urandom);
            grf_ready = ($urandom_range(0, 3) != 0);
            q_addr1   = 5'($urandom_range(0, 7));
            q_addr2   = 5'($urandom_range(0, 7));
            cyc();
        end
        in_valid = 1'b0;
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
